// File: rtl/up_down_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// up_down_sweep_ctrl
//
// Sequencer for an external WIDTH-bit up/down counter. A start request clears
// the counter, then runs N sweeps of 0 -> LIMIT -> 0 before pulsing done.
// LIMIT and N are latched at start, so the inputs may change during a run.
//
// Optional feature: define UDC_DWELL_EN to insert a DWELL state between UP
// and DOWN that holds the counter at LIMIT for DWELL_CYCLES cycles.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   start        in   start request, sampled only while idle
//   abort        in   synchronous abort, ignored while idle
//   limit_in     in   sweep top value (WIDTH bits)
//   sweeps_in    in   number of sweeps, 0 behaves as 1
//   counter_in   in   registered value from the counter datapath
//   cnt_en       out  counter advances on the next edge
//   up_down_flag out  1 = count up, 0 = count down
//   cnt_clear    out  counter goes to 0 on the next edge (overrides cnt_en)
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on normal completion
//   sweep_cnt    out  completed sweeps in the current run
// -----------------------------------------------------------------------------
module up_down_sweep_ctrl #(
    parameter int WIDTH        = 4,
    parameter int DWELL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] limit_in,
    input  logic [7:0]       sweeps_in,
    input  logic [WIDTH-1:0] counter_in,
    output logic             cnt_en,
    output logic             up_down_flag,
    output logic             cnt_clear,
    output logic             busy,
    output logic             done,
    output logic [7:0]       sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_UP    = 3'd2,
        S_DWELL = 3'd3,
        S_DOWN  = 3'd4,
        S_DONE  = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_limit;
    logic [7:0]       r_sweeps;
    logic [7:0]       r_sweep_cnt;
    logic             w_latch;
    logic             w_sweep_inc;
    logic             w_at_limit;
    logic             w_at_zero;
    logic [7:0]       w_sweep_cnt_inc;

`ifdef UDC_DWELL_EN
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [DW_W-1:0] r_dwell;
    logic            w_dwell_last;
    assign w_dwell_last = (r_dwell == DW_W'(DWELL_CYCLES - 1));
`else
    logic w_unused_dwell;
    assign w_unused_dwell = (DWELL_CYCLES != 0);
`endif

    assign w_at_limit      = (counter_in == r_limit);
    assign w_at_zero       = (counter_in == '0);
    assign w_sweep_cnt_inc = r_sweep_cnt + 8'd1;
    assign sweep_cnt       = r_sweep_cnt;

    // Next-state and outputs. cnt_en is combinational on counter_in so the
    // counter is stopped in the very cycle it reaches LIMIT or 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_sweep_inc  = 1'b0;
        cnt_en       = 1'b0;
        up_down_flag = 1'b1;
        cnt_clear    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clear   = 1'b1;
                w_state_nxt = S_UP;
            end
            S_UP: begin
                cnt_en = !w_at_limit;
                if (w_at_limit) begin
`ifdef UDC_DWELL_EN
                    w_state_nxt = S_DWELL;
`else
                    w_state_nxt = S_DOWN;
`endif
                end
            end
`ifdef UDC_DWELL_EN
            S_DWELL: begin
                if (w_dwell_last) begin
                    w_state_nxt = S_DOWN;
                end
            end
`endif
            S_DOWN: begin
                up_down_flag = 1'b0;
                cnt_en       = !w_at_zero;
                if (w_at_zero) begin
                    w_sweep_inc = 1'b1;
                    w_state_nxt = (w_sweep_cnt_inc == r_sweeps) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ABORT: begin
                cnt_clear   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides every transition out of a busy state, including the
        // sweep count update of a DOWN cycle that reaches 0.
        if (r_state != S_IDLE && abort) begin
            w_state_nxt = S_ABORT;
            w_sweep_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_limit     <= '0;
            r_sweeps    <= 8'd1;
            r_sweep_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_limit     <= limit_in;
                r_sweeps    <= (sweeps_in == 8'd0) ? 8'd1 : sweeps_in;
                r_sweep_cnt <= 8'd0;
            end else if (w_sweep_inc) begin
                r_sweep_cnt <= w_sweep_cnt_inc;
            end
        end
    end

`ifdef UDC_DWELL_EN
    // Cycle counter inside DWELL; restarts whenever DWELL is not occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell <= '0;
        end else if (r_state == S_DWELL && w_state_nxt == S_DWELL) begin
            r_dwell <= r_dwell + 1'b1;
        end else begin
            r_dwell <= '0;
        end
    end
`endif

endmodule
